io_start_ctrl: RTL
==================

// Module: io_start_ctrl
// PURPOSE
//  Produces the startIO flag consumed by the segmented memory (read-only at data address RAMSIZE*7).
//  Synchronises and debounces the external start button and holds a sticky start request.
//  Software clears or sets the flag with a store to the IO address; the block snoops the data port.
//  Sits between the board pin and the memory startIO input.
// PARAMETERS
//  WIDTH            32     data/address width of the snooped data port
//  RAMSIZE          512    words per segment; IO address = RAMSIZE*7 (3584 at default)
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles required to accept a level change (>=2)
//  CNT_WIDTH        $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived, do not override)
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  btn_raw      in   1      start button pin, asynchronous, active-high
//  we           in   1      data-port write enable (snooped, same signal driven to memory)
//  a2           in   WIDTH  data-port address (snooped)
//  wd           in   WIDTH  data-port write data (snooped)
//  startIO      out  1      sticky start request to memory
//  btn_level    out  1      debounced button level
//  press_count  out  8      accepted press counter, wraps
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): sync FFs, btn_level, startIO, press_count, counter -> 0; FSM -> IDLE_LO.
//  Sync: 2-FF chain btn_raw -> s1 -> s2; only s2 used downstream.
//  Debounce FSM (counter cnt):
//   IDLE_LO: s2=1 -> CHK_HI, cnt=0.
//   CHK_HI:  s2=0 -> IDLE_LO, cnt=0; s2=1 & cnt=DEBOUNCE_CYCLES-1 -> IDLE_HI, btn_level=1; else cnt++.
//   IDLE_HI: s2=0 -> CHK_LO, cnt=0.
//   CHK_LO:  mirror of CHK_HI; on completion -> IDLE_LO, btn_level=0.
//   cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
//  press pulse: registered 1-cycle pulse the cycle after btn_level 0->1; nothing on 1->0.
//  Latency: btn_raw set up before edge 0 and held -> btn_level=1 after edge DEBOUNCE_CYCLES+2,
//   startIO=1 after edge DEBOUNCE_CYCLES+3.
//  IO store: io_wr = we & (a2 == RAMSIZE*7), full-width compare.
//  startIO next state, priority high->low:
//   press pulse           -> 1
//   io_wr & wd[0]=1       -> 1 (software trigger)
//   io_wr & wd[0]=0       -> 0 (acknowledge/clear)
//   else hold
//  Simultaneous press pulse and clear store: set wins; press is never lost.
//  Store effect visible on startIO the cycle after the write cycle; wd[WIDTH-1:1] ignored.
//  press_count: +1 on every press pulse, even if startIO already 1; 255 -> 0; software writes never change it.
//  Reset mid-check: debounce progress discarded.
//   Button held through reset is re-debounced from IDLE_LO, producing one press after release.
//  Stores to any other address, including RAMSIZE*7 +/- 1, have no effect.
// TESTING (DEBOUNCE_CYCLES=4, RAMSIZE=512)
//  T1 rst_n=0 3 cycles, btn_raw=1 throughout -> outputs 0 in reset; startIO=1 after 7th edge post-release, press_count=1.
//  T2 btn_raw=1 for 3 cycles then 0 -> btn_level, startIO, press_count stay 0.
//  T3 clean press, then we=1 a2=3583 wd=0 -> startIO stays 1; then a2=3584 wd=0 -> startIO=0 next cycle.
//  T4 clear store (a2=3584 wd=0) in the same cycle as the press pulse -> startIO=1, press_count +1.
//  T5 startIO=0, we=1 a2=3584 wd=32'h1 -> startIO=1 next cycle, press_count unchanged.
//  T6 256 clean presses with release between -> press_count returns to 0; btn_level low after each release.

Source files
------------

// File: rtl/io_start_ctrl.sv
// io_start_ctrl
//   Generates the sticky startIO flag read by the segmented memory. The
//   external start button is synchronised, debounced and turned into a
//   single press pulse that sets the flag; software sets or clears the flag
//   by storing to the IO address (RAMSIZE*7), observed by snooping the data
//   port that also feeds the memory.
//
// Ports
//   clk          in   1      system clock, all state on the rising edge
//   rst_n        in   1      synchronous reset, active-low
//   btn_raw      in   1      start button pin, asynchronous, active-high
//   we           in   1      snooped data-port write enable
//   a2           in   WIDTH  snooped data-port address
//   wd           in   WIDTH  snooped data-port write data (only bit 0 matters)
//   startIO      out  1      sticky start request to memory
//   btn_level    out  1      debounced button level
//   press_count  out  8      accepted press counter, wraps 255 -> 0
module io_start_ctrl #(
  parameter int WIDTH           = 32,
  parameter int RAMSIZE         = 512,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic             we,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] wd,
  output logic             startIO,
  output logic             btn_level,
  output logic [7:0]       press_count
);

  localparam logic [WIDTH-1:0]     IO_ADDR  = WIDTH'(RAMSIZE * 7);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
  logic                 sync1_r, sync2_r;
  logic                 level_r, level_s;
  logic                 press_r, press_s;
  logic                 start_r, start_s;
  logic [7:0]           count_r, count_s;
  logic                 io_wr_s;
  logic                 wd_unused_s;

  // Upper write-data bits carry no meaning for the IO flag.
  assign wd_unused_s = ^wd[WIDTH-1:1];

  // Full-width address match: neighbouring addresses must not alias.
  assign io_wr_s = we & (a2 == IO_ADDR);

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM next state. The press pulse is raised on the same edge
  // that sets btn_level so it is visible in the cycle after the rise.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    level_s = level_r;
    press_s = 1'b0;
    case (state_r)
      IDLE_LO: begin
        if (sync2_r) begin
          state_s = CHK_HI;
          cnt_s   = '0;
        end else begin
          state_s = IDLE_LO;
        end
      end
      CHK_HI: begin
        if (!sync2_r) begin
          state_s = IDLE_LO;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = IDLE_HI;
          cnt_s   = '0;
          level_s = 1'b1;
          press_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync2_r) begin
          state_s = CHK_LO;
          cnt_s   = '0;
        end else begin
          state_s = IDLE_HI;
        end
      end
      CHK_LO: begin
        if (sync2_r) begin
          state_s = IDLE_HI;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = IDLE_LO;
          cnt_s   = '0;
          level_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE_LO;
        cnt_s   = '0;
        level_s = 1'b0;
      end
    endcase
  end

  // startIO next state: a press always wins over a software clear so a
  // press is never lost; press_count ignores software stores.
  always_comb begin
    start_s = start_r;
    count_s = count_r;
    if (press_r) begin
      start_s = 1'b1;
      count_s = count_r + 8'd1;
    end else if (io_wr_s && wd[0]) begin
      start_s = 1'b1;
    end else if (io_wr_s) begin
      start_s = 1'b0;
    end else begin
      start_s = start_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE_LO;
      cnt_r   <= '0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      start_r <= 1'b0;
      count_r <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
      press_r <= press_s;
      start_r <= start_s;
      count_r <= count_s;
    end
  end

  assign startIO     = start_r;
  assign btn_level   = level_r;
  assign press_count = count_r;

endmodule
